// File: rtl/branch_pred_unit_if.sv
// Fetch/execute-facing bundle of the branch predictor: lookup request/response
// and resolved-branch update channels. Clock and reset stay outside.
interface branch_pred_unit_if #(
  parameter int PC_W  = 12,
  parameter int GHR_W = 8
);
  logic             ready;

  logic             pred_req;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic             pred_hit;
  logic [PC_W-1:0]  pred_target;
  logic [GHR_W-1:0] pred_ghr;

  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_target;
  logic [GHR_W-1:0] upd_ghr;

  modport master (
    input  ready, pred_valid, pred_taken, pred_hit, pred_target, pred_ghr,
    output pred_req, pred_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_ghr
  );

  modport slave (
    output ready, pred_valid, pred_taken, pred_hit, pred_target, pred_ghr,
    input  pred_req, pred_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_ghr
  );
endinterface

// File: rtl/branch_pred_unit.sv
// Branch predictor: 2-bit counter table plus fully associative round-robin BTB.
// Define BP_GSHARE_EN to XOR global history into the counter index.
module branch_pred_unit #(
  parameter int         PC_W        = 12,
  parameter int         BHT_ENTRIES = 1024,
  parameter int         BTB_ENTRIES = 32,
  parameter logic [1:0] CTR_INIT    = 2'b01,
  parameter int         GHR_W       = 8
) (
  input logic                clk,
  input logic                rst,
  branch_pred_unit_if.slave  bp
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W = PC_W - 2;
  localparam int PTR_W = $clog2(BTB_ENTRIES);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             run;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // NOTE: defaults first so no path through this block leaves a latch.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      S_INIT: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(BHT_ENTRIES - 1)) state_d = S_RUN;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  assign run      = (state_q == S_RUN);
  assign bp.ready = run;

  // ---------------- index generation ----------------
  logic [IDX_W-1:0] pred_idx, upd_idx;
  logic [GHR_W-1:0] ghr_snap;

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (run && bp.upd_valid) ghr_d = {ghr_q[GHR_W-2:0], bp.upd_taken};
  end

  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

  assign pred_idx = bp.pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign upd_idx  = bp.upd_pc[IDX_W+1:2] ^ IDX_W'(bp.upd_ghr);
  assign ghr_snap = ghr_q;

  logic unused_bits;
  assign unused_bits = ^{bp.pred_pc[1:0], bp.upd_pc[1:0]};
`else
  assign pred_idx = bp.pred_pc[IDX_W+1:2];
  assign upd_idx  = bp.upd_pc[IDX_W+1:2];
  assign ghr_snap = '0;

  logic unused_bits;
  assign unused_bits = ^{bp.pred_pc[1:0], bp.upd_pc[1:0], bp.upd_ghr};
`endif

  // ---------------- counter table ----------------
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       pred_ctr, upd_ctr;
  logic             bht_we;
  logic [IDX_W-1:0] bht_widx;
  logic [1:0]       bht_wdata;

  assign pred_ctr = bht_q[pred_idx];
  assign upd_ctr  = bht_q[upd_idx];

  always_comb begin
    bht_we    = 1'b0;
    bht_widx  = upd_idx;
    bht_wdata = upd_ctr;
    if (!rst) begin
      if (!run) begin
        bht_we    = 1'b1;
        bht_widx  = sweep_q;
        bht_wdata = CTR_INIT;
      end else if (bp.upd_valid) begin
        bht_we = 1'b1;
        if (bp.upd_taken) bht_wdata = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'b01;
        else              bht_wdata = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'b01;
      end
    end
  end

  // NOTE: the table has no reset; the post-reset sweep initialises it.
  always_ff @(posedge clk) begin
    if (bht_we) bht_q[bht_widx] <= bht_wdata;
  end

  // ---------------- branch target buffer ----------------
  logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [PC_W-1:0]        btb_tgt_q [BTB_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_vld_q;
  logic [PTR_W-1:0]       ptr_q, ptr_d;

  logic             look_hit, upd_hit, btb_we;
  logic [PC_W-1:0]  look_tgt;
  logic [PTR_W-1:0] upd_slot, btb_wslot;

  always_comb begin
    look_hit = 1'b0;
    look_tgt = '0;
    upd_hit  = 1'b0;
    upd_slot = '0;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      if (btb_vld_q[i] && btb_tag_q[i] == bp.pred_pc[PC_W-1:2]) begin
        look_hit = 1'b1;
        look_tgt = btb_tgt_q[i];
      end
      if (btb_vld_q[i] && btb_tag_q[i] == bp.upd_pc[PC_W-1:2]) begin
        upd_hit  = 1'b1;
        upd_slot = PTR_W'(i);
      end
    end
  end

  // An existing tag is retargeted in place, which keeps tags unique.
  assign btb_we    = !rst && run && bp.upd_valid && bp.upd_taken;
  assign btb_wslot = upd_hit ? upd_slot : ptr_q;
  assign ptr_d     = (btb_we && !upd_hit) ? ptr_q + PTR_W'(1) : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_vld_q <= '0;
      ptr_q     <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (btb_we) btb_vld_q[btb_wslot] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag_q[btb_wslot] <= bp.upd_pc[PC_W-1:2];
      btb_tgt_q[btb_wslot] <= bp.upd_target;
    end
  end

  // ---------------- registered response ----------------
  logic             pvalid_q, ptaken_q, phit_q;
  logic [PC_W-1:0]  ptarget_q;
  logic [GHR_W-1:0] pghr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pvalid_q  <= 1'b0;
      ptaken_q  <= 1'b0;
      phit_q    <= 1'b0;
      ptarget_q <= '0;
      pghr_q    <= '0;
    end else if (run && bp.pred_req) begin
      pvalid_q  <= 1'b1;
      ptaken_q  <= look_hit & pred_ctr[1];
      phit_q    <= look_hit;
      ptarget_q <= look_hit ? look_tgt : bp.pred_pc + PC_W'(4);
      pghr_q    <= ghr_snap;
    end else begin
      pvalid_q  <= 1'b0;
    end
  end

  assign bp.pred_valid  = pvalid_q;
  assign bp.pred_taken  = ptaken_q;
  assign bp.pred_hit    = phit_q;
  assign bp.pred_target = ptarget_q;
  assign bp.pred_ghr    = pghr_q;
endmodule

// File: tb/tb_branch_pred_unit.sv
// Scoreboard bench for branch_pred_unit: directed stimulus pushes expected
// responses, a negedge monitor pops and compares them on every pred_valid.
module tb_branch_pred_unit;
  localparam int PC_W  = 12;
  localparam int GHR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_pred_unit_if #(.PC_W(PC_W), .GHR_W(GHR_W)) bp ();

  branch_pred_unit #(
    .PC_W(PC_W), .BHT_ENTRIES(1024), .BTB_ENTRIES(32), .CTR_INIT(2'b01), .GHR_W(GHR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bp)
  );

  typedef struct {
    string            name;
    logic             taken;
    logic             hit;
    logic [PC_W-1:0]  target;
    logic [GHR_W-1:0] ghr;
  } resp_t;

  resp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response strobe must match the oldest expected entry.
  resp_t got;
  always @(negedge clk) begin
    if (bp.pred_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pred_valid", bp.pred_valid, 1'b0);
      end else begin
        got = exp_q.pop_front();
        check({got.name, ".taken"},  bp.pred_taken,  got.taken);
        check({got.name, ".hit"},    bp.pred_hit,    got.hit);
        check({got.name, ".target"}, bp.pred_target, got.target);
        check({got.name, ".ghr"},    bp.pred_ghr,    got.ghr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input string nm, input logic t, input logic h,
                             input logic [PC_W-1:0] tg, input logic [GHR_W-1:0] g);
    resp_t e;
    e.name = nm; e.taken = t; e.hit = h; e.target = tg; e.ghr = g;
    exp_q.push_back(e);
  endtask

  task automatic predict(input string nm, input logic [PC_W-1:0] pc, input logic t,
                         input logic h, input logic [PC_W-1:0] tg, input logic [GHR_W-1:0] g);
    expect_resp(nm, t, h, tg, g);
    bp.pred_req = 1'b1;
    bp.pred_pc  = pc;
    tick();
    bp.pred_req = 1'b0;
  endtask

  task automatic update(input logic [PC_W-1:0] pc, input logic taken,
                        input logic [PC_W-1:0] tgt, input logic [GHR_W-1:0] g);
    bp.upd_valid  = 1'b1;
    bp.upd_pc     = pc;
    bp.upd_taken  = taken;
    bp.upd_target = tgt;
    bp.upd_ghr    = g;
    tick();
    bp.upd_valid  = 1'b0;
  endtask

  // Counts edges after reset release until ready; must be exactly 1024.
  task automatic wait_ready(input string nm);
    int n = 0;
    do begin
      tick();
      n++;
      if (n == 10) check({nm, ".no_valid_in_sweep"}, bp.pred_valid, 1'b0);
    end while (bp.ready !== 1'b1 && n < 1100);
    bp.pred_req  = 1'b0;
    bp.upd_valid = 1'b0;
    check(nm, n, 1024);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bp.pred_req = 1'b0; bp.pred_pc = '0;
    bp.upd_valid = 1'b0; bp.upd_pc = '0; bp.upd_taken = 1'b0;
    bp.upd_target = '0; bp.upd_ghr = '0;

    // Reset and sweep; requests and updates during the sweep are ignored.
    rst = 1'b1;
    repeat (2) tick();
    check("rst.ready",  bp.ready,       1'b0);
    check("rst.valid",  bp.pred_valid,  1'b0);
    check("rst.taken",  bp.pred_taken,  1'b0);
    check("rst.hit",    bp.pred_hit,    1'b0);
    check("rst.target", bp.pred_target, 12'h000);
    check("rst.ghr",    bp.pred_ghr,    8'h00);
    rst = 1'b0;
    bp.pred_req = 1'b1; bp.pred_pc = 12'h100;
    bp.upd_valid = 1'b1; bp.upd_pc = 12'h100; bp.upd_taken = 1'b1; bp.upd_target = 12'h180;
    wait_ready("ready_after_reset");

`ifdef BP_GSHARE_EN
    update(12'h030, 1'b1, 12'h070, 8'h10);   // idx 0x1C, GHR -> 01
    update(12'h000, 1'b1, 12'h040, 8'h05);   // idx 0x05, GHR -> 03
    predict("gs_idx3", 12'h000, 1'b0, 1'b1, 12'h040, 8'h03);
    update(12'h03C, 1'b1, 12'h060, 8'h20);   // idx 0x2F, GHR -> 07
    update(12'h000, 1'b1, 12'h040, 8'h03);   // trains idx 3, GHR -> 0F
    predict("gs_read_idx3", 12'h030, 1'b1, 1'b1, 12'h070, 8'h0F);
    predict("gs_read_idx0", 12'h03C, 1'b0, 1'b1, 12'h060, 8'h0F);
`else
    // Post-sweep counters are weakly not-taken; empty BTB, pc+4 wraps.
    predict("init_040", 12'h040, 1'b0, 1'b0, 12'h044, 8'h00);
    predict("init_ffc", 12'hFFC, 1'b0, 1'b0, 12'h000, 8'h00);
    predict("init_100", 12'h100, 1'b0, 1'b0, 12'h104, 8'h00);

    // Saturation at 3, then decay; not-taken updates leave the BTB alone.
    repeat (3) update(12'h040, 1'b1, 12'h200, 8'h00);
    predict("sat_3taken", 12'h040, 1'b1, 1'b1, 12'h200, 8'h00);
    update(12'h040, 1'b1, 12'h200, 8'h00);
    update(12'h040, 1'b0, 12'h777, 8'h00);
    predict("sat_1nt", 12'h040, 1'b1, 1'b1, 12'h200, 8'h00);
    update(12'h040, 1'b0, 12'h777, 8'h00);
    predict("sat_2nt", 12'h040, 1'b0, 1'b1, 12'h200, 8'h00);

    // Reset mid-sweep restarts the sweep and clears the BTB.
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (500) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    wait_ready("ready_after_mid_rst");
    predict("cleared_040", 12'h040, 1'b0, 1'b0, 12'h044, 8'h00);

    // BTB fill: 33 distinct taken branches, the 33rd evicts entry 0.
    for (int i = 0; i <= 32; i++)
      update(12'(i * 4), 1'b1, 12'(i * 4 + 'h400), 8'h00);
    predict("fill_000_evicted", 12'h000, 1'b0, 1'b0, 12'h004, 8'h00);
    predict("fill_080_hit",     12'h080, 1'b1, 1'b1, 12'h480, 8'h00);
    predict("fill_004_hit",     12'h004, 1'b1, 1'b1, 12'h404, 8'h00);
    update(12'h080, 1'b1, 12'h300, 8'h00);
    predict("retarget_080",     12'h080, 1'b1, 1'b1, 12'h300, 8'h00);
    update(12'h0C0, 1'b1, 12'h5C0, 8'h00);   // lands on slot 1 only if pointer held
    predict("ptr_004_evicted",  12'h004, 1'b0, 1'b0, 12'h008, 8'h00);
    predict("ptr_008_kept",     12'h008, 1'b1, 1'b1, 12'h408, 8'h00);
    predict("ptr_0c0_new",      12'h0C0, 1'b1, 1'b1, 12'h5C0, 8'h00);
    tick();
    check("hold.valid",  bp.pred_valid,  1'b0);
    check("hold.target", bp.pred_target, 12'h5C0);

    // Same-cycle update and lookup on 0x100: read before write.
    expect_resp("collide_same", 1'b0, 1'b0, 12'h104, 8'h00);
    bp.pred_req = 1'b1; bp.pred_pc = 12'h100;
    bp.upd_valid = 1'b1; bp.upd_pc = 12'h100; bp.upd_taken = 1'b1;
    bp.upd_target = 12'h180; bp.upd_ghr = 8'h00;
    tick();
    bp.upd_valid = 1'b0;
    predict("collide_next", 12'h100, 1'b1, 1'b1, 12'h180, 8'h00);
`endif

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_pred_unit.md
# branch_pred_unit

Clocked, parametrised branch predictor for the fetch stage. It combines a direct-mapped table of 2-bit saturating counters with a fully associative branch target buffer that uses round-robin replacement. It answers one lookup per cycle with a registered taken/target prediction, and it accepts one resolved-branch update per cycle from execute. A post-reset sweep initialises the counter table, and `ready` is low until the sweep finishes.

## Interface
Parameters:
- `PC_W`, 12: PC width in bits. PCs are byte addresses, and bits [1:0] are ignored.
- `BHT_ENTRIES`, 1024: number of counters. Must be a power of two. `IDX_W` = log2(`BHT_ENTRIES`), with `IDX_W` ≤ `PC_W`-2.
- `BTB_ENTRIES`, 32: number of BTB entries. Must be a power of two.
- `CTR_INIT`, 2'b01: counter value written by the sweep (weakly not-taken).
- `GHR_W`, 8: global history width. Only used under `BP_GSHARE_EN`. `GHR_W` ≤ `IDX_W`.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock. Single clock domain, rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `ready`, out, 1: high once the init sweep is complete.
- `pred_req`, in, 1: lookup request.
- `pred_pc`, in, `PC_W`: PC to predict.
- `pred_valid`, out, 1: response strobe.
- `pred_taken`, out, 1: predicted direction.
- `pred_hit`, out, 1: BTB tag match.
- `pred_target`, out, `PC_W`: predicted target.
- `pred_ghr`, out, `GHR_W`: history snapshot used for this lookup.
- `upd_valid`, in, 1: resolved conditional branch.
- `upd_pc`, in, `PC_W`: PC of the resolved branch.
- `upd_taken`, in, 1: actual outcome.
- `upd_target`, in, `PC_W`: actual target.
- `upd_ghr`, in, `GHR_W`: the `pred_ghr` value that travelled with this branch.

## Operation
State machine: INIT → RUN.
- On `rst`:
  - Enter INIT with sweep index 0.
  - Clear all BTB valid bits, the BTB replacement pointer and the GHR.
  - Drive `ready`, `pred_valid`, `pred_taken` and `pred_hit` to 0, and `pred_target` and `pred_ghr` to 0.
- INIT:
  - Write `CTR_INIT` to `BHT[idx]` once per cycle, for idx 0 .. `BHT_ENTRIES`-1.
  - After the write to the last index, go to RUN and set `ready`=1.
  - `pred_req` and `upd_valid` are ignored; `pred_valid` stays 0.
  - `rst` asserted mid-sweep restarts the sweep at 0.
- Index (base): idx = pc[`IDX_W`+1:2].
- Prediction (RUN, `pred_req`=1):
  - `pred_taken` = BHT[idx] MSB.
  - BTB lookup compares pc[`PC_W`-1:2] against every valid tag. On a match, `pred_hit`=1 and `pred_target` = the stored target.
  - On a miss, `pred_hit`=0, `pred_target` = `pred_pc`+4 (wraps modulo 2^`PC_W`), and `pred_taken` is forced to 0.
  - At most one BTB entry may match; the update rule below guarantees this.
- Update (RUN, `upd_valid`=1):
  - Counter: taken increments, saturating at 3; not-taken decrements, saturating at 0.
  - BTB, taken branches only:
    - If the tag already exists, overwrite its target in place and leave the pointer unchanged.
    - Otherwise write tag, target and valid at the pointer, then advance the pointer. It wraps from `BTB_ENTRIES`-1 to 0.
  - Not-taken updates never modify the BTB.
- Same-cycle prediction and update on the same index or tag:
  - The prediction returns the pre-update value (read before write).
  - The update takes effect for requests issued in the next cycle and later.

## Timing
- Prediction latency: one cycle. A `pred_req` at edge N gives `pred_valid`=1 plus its data after edge N+1. Fully pipelined, one request per cycle.
- Response hold: with no request, `pred_valid`=0 and the data outputs hold their last values.
- Update commit: at the edge where `upd_valid` is sampled. No backpressure; every update is accepted when `ready`=1.
- `ready` rises exactly `BHT_ENTRIES` cycles after the last cycle `rst` is high.

## Configuration
`BP_GSHARE_EN`:
- Defined:
  - Prediction index = pc[`IDX_W`+1:2] XOR {zero-extended GHR}.
  - Update index = pc[`IDX_W`+1:2] XOR {zero-extended `upd_ghr`}.
  - On each `upd_valid`, the GHR shifts left with `upd_taken` entering at the LSB.
  - `pred_ghr` = the GHR value used for the lookup.
- Undefined:
  - No GHR register; `pred_ghr` is tied to 0 and `upd_ghr` is ignored.
  - Index is the base index only.

## Test plan
- **Reset and sweep:** assert `rst` for 2 cycles, then release. `ready`=0 for exactly 1024 cycles, then 1. A `pred_req` during the sweep gives `pred_valid`=0. Sample lookups afterwards read counter 01, so `pred_taken`=0.
- **Saturation:** 3 taken updates at PC 0x040, then predict → `pred_taken`=1, counter 3. A 4th taken update keeps the counter at 3. Then 2 not-taken updates → `pred_taken`=0.
- **BTB fill, wrap and retarget:**
  - 33 taken updates to distinct PCs 0x000..0x080, step 4. The lookup of 0x000 now misses with `pred_target`=0x004; the lookup of 0x080 hits.
  - Retarget 0x080 to 0x300 → hit with target 0x300, and the pointer does not advance.
- **Same-cycle collision:** counter at 1; a taken update and a `pred_req` on 0x100 in the same cycle. The response is `pred_taken`=0; a request the next cycle gives 1.
- **Reset mid-sweep:** assert `rst` at sweep index 500. The sweep restarts, and `ready` rises 1024 cycles after release.
- **Gshare (`BP_GSHARE_EN` defined):** after taken updates that set GHR=8'h03, a prediction of 0x000 uses index 3. Updating with `upd_ghr`=8'h03 trains index 3 and not index 0.
